// File: rtl/mult_ctrl_if.sv
// mult_ctrl_if
// Handshake and data bundle between the decode stage and the multiplier
// controller.
//
// Signals:
//   start  - request a multiply of Rs by Rt
//   flush  - synchronous abort of an in-flight multiply
//   Rs     - 16-bit multiplicand
//   Rt     - 16-bit multiplier
//   busy   - high while the multiplier is iterating (stall request)
//   done   - one-cycle pulse, res/ovf valid
//   res    - low 16 bits of the unsigned product
//   ovf    - any of product bits [31:16] set
//
// Modports:
//   master - requester side (drives start/flush/operands)
//   slave  - multiplier side (mult_ctrl)
interface mult_ctrl_if;
    logic        start;
    logic        flush;
    logic [15:0] Rs;
    logic [15:0] Rt;
    logic        busy;
    logic        done;
    logic [15:0] res;
    logic        ovf;

    modport master (
        output start, flush, Rs, Rt,
        input  busy, done, res, ovf
    );

    modport slave (
        input  start, flush, Rs, Rt,
        output busy, done, res, ovf
    );
endinterface

// File: rtl/mult_ctrl.sv
// mult_ctrl
// Sequential shift-and-add 16x16 unsigned multiplier controller with an
// IDLE/RUN/DONE state machine. One multiplier bit is consumed per RUN cycle.
// The result registers only move when a multiply completes, so res/ovf
// hold the last completed product through any later RUN, flush or ignored
// start.
//
// Ports:
//   clk - single clock, rising edge
//   rst - asynchronous active-high reset
//   mul - mult_ctrl_if.slave (start, flush, Rs, Rt in; busy, done, res, ovf out)
//
// Configuration:
//   MULT_EARLY_EXIT_EN - when defined, RUN ends as soon as the remaining
//   multiplier bits are all zero (Rt==0 skips RUN entirely). Results are
//   identical to the default build; only latency changes.
module mult_ctrl (
    input  logic       clk,
    input  logic       rst,
    mult_ctrl_if.slave mul
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] mcand;
    logic [31:0] acc;
    logic [15:0] mplier;
    logic [3:0]  count;
    logic [15:0] res_q;
    logic        ovf_q;

    logic        load;
    logic        step;
    logic        capture;
    logic [31:0] acc_sum;
    logic [15:0] mplier_shift;
    logic        last_step;
    logic [15:0] res_next;
    logic        ovf_next;

    // Partial-product accumulate for the current multiplier LSB; the sum
    // wraps at 32 bits, which cannot happen for 16x16 operands anyway.
    assign acc_sum      = acc + (mplier[0] ? mcand : 32'h0000_0000);
    assign mplier_shift = {1'b0, mplier[15:1]};

`ifdef MULT_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain after this cycle's shift.
    assign last_step = (count == 4'd15) || (mplier_shift == 16'h0000);
`else
    assign last_step = (count == 4'd15);
`endif

    assign mul.busy = (state == RUN);
    assign mul.done = (state == DONE);
    assign mul.res  = res_q;
    assign mul.ovf  = ovf_q;

    // Next-state and datapath control. A start is only honoured outside
    // RUN; flush overrides everything, including a start in the same cycle
    // and a completion that would otherwise capture a result.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        res_next   = acc_sum[15:0];
        ovf_next   = |acc_sum[31:16];

        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (mul.start) begin
                    load       = 1'b1;
                    state_next = RUN;
`ifdef MULT_EARLY_EXIT_EN
                    // Zero multiplier: product is known, skip RUN.
                    if (mul.Rt == 16'h0000) begin
                        state_next = DONE;
                        capture    = 1'b1;
                        res_next   = 16'h0000;
                        ovf_next   = 1'b0;
                    end
`endif
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (mul.flush) begin
            state_next = IDLE;
            load       = 1'b0;
            step       = 1'b0;
            capture    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift-and-add datapath: load operands on an accepted start, then one
    // multiplier bit per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= 32'h0000_0000;
            mplier <= 16'h0000;
            acc    <= 32'h0000_0000;
            count  <= 4'd0;
        end else if (load) begin
            mcand  <= {16'h0000, mul.Rs};
            mplier <= mul.Rt;
            acc    <= 32'h0000_0000;
            count  <= 4'd0;
        end else if (step) begin
            acc    <= acc_sum;
            mcand  <= {mcand[30:0], 1'b0};
            mplier <= mplier_shift;
            count  <= count + 4'd1;
        end
    end

    // Result registers: written only when a multiply completes, using the
    // sum produced in that final RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= 16'h0000;
            ovf_q <= 1'b0;
        end else if (capture) begin
            res_q <= res_next;
            ovf_q <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl
// Self-checking bench for mult_ctrl. Stimulus tasks push the expected
// result and completion cycle into a scoreboard queue; a monitor pops and
// compares whenever done is presented.
module tb_mult_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mult_ctrl_if mul ();

    mult_ctrl dut (
        .clk (clk),
        .rst (rst),
        .mul (mul)
    );

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cycle = 0;
    int          tests = 0;
    int          failures = 0;
    logic [15:0] exp_last_res;

    // Rising-edge counter used to time-stamp expected done pulses.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Number of RUN cycles expected for a given multiplier.
    function automatic int expRunLen(input logic [15:0] rt);
        int n;
        n = 16;
`ifdef MULT_EARLY_EXIT_EN
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (rt[i]) n = i + 1;
        end
`endif
        return n;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && mul.done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_res"}, {16'h0, mul.res}, {16'h0, e.res});
                checkOutput({e.name, "_ovf"}, {31'h0, mul.ovf}, {31'h0, e.ovf});
                checkOutput({e.name, "_cycle"}, cycle, e.cyc);
            end
        end
    end

    // Issue one start (called just after a falling edge); returns one
    // falling edge later with start released.
    task automatic applyStimulus(input string name, input logic [15:0] rs,
                                 input logic [15:0] rt, input logic [15:0] exp_res,
                                 input logic exp_ovf);
        exp_t e;
        mul.Rs    = rs;
        mul.Rt    = rt;
        mul.start = 1'b1;
        e.res     = exp_res;
        e.ovf     = exp_ovf;
        e.cyc     = cycle + 1 + expRunLen(rt);
        e.name    = name;
        sb.push_back(e);
        @(negedge clk);
        mul.start = 1'b0;
    endtask

    // Wait for done (bounded), counting busy cycles and watching that res
    // holds the previous result during RUN. Optionally pulses a start with
    // different operands at loop index 'inject', which must be ignored.
    task automatic waitDrain(input string name, input logic [15:0] rt,
                             input logic [15:0] exp_res, input int inject);
        int busy_cnt = 0;
        bit seen = 1'b0;
        bit res_moved = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mul.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (mul.busy === 1'b1) begin
                busy_cnt++;
                if (mul.res !== exp_last_res) res_moved = 1'b1;
            end
            mul.start = (i == inject);
            if (i == inject) begin
                mul.Rs = 16'h0009;
                mul.Rt = 16'h0009;
            end
            @(negedge clk);
        end
        mul.start = 1'b0;
        checkOutput({name, "_done_seen"}, {31'h0, seen}, 32'd1);
        checkOutput({name, "_busy_cycles"}, busy_cnt, expRunLen(rt));
        checkOutput({name, "_res_stable"}, {31'h0, res_moved}, 32'd0);
        exp_last_res = exp_res;
    endtask

    logic [15:0] vec_rs  [7] = '{16'h0100, 16'hFFFF, 16'h1234, 16'h0007, 16'h00FF, 16'h8000, 16'h0001};
    logic [15:0] vec_rt  [7] = '{16'h0100, 16'hFFFF, 16'h0000, 16'h0001, 16'h0101, 16'h0002, 16'h8000};
    logic [15:0] vec_res [7] = '{16'h0000, 16'h0001, 16'h0000, 16'h0007, 16'hFFFF, 16'h0000, 16'h8000};
    logic        vec_ovf [7] = '{1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0};

    initial begin
        mul.start    = 1'b0;
        mul.flush    = 1'b0;
        mul.Rs       = 16'h0000;
        mul.Rt       = 16'h0000;
        exp_last_res = 16'h0000;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'h0, mul.busy}, 32'd0);
        checkOutput("reset_done", {31'h0, mul.done}, 32'd0);
        checkOutput("reset_res", {16'h0, mul.res}, 32'h0);
        checkOutput("reset_ovf", {31'h0, mul.ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3*5 with a start of other operands during RUN that must be ignored.
        applyStimulus("mul3x5", 16'h0003, 16'h0005, 16'h000F, 1'b0);
        waitDrain("mul3x5", 16'h0005, 16'h000F, 1);
        @(negedge clk);

        // Flush at the sixth RUN cycle: back to IDLE, no done, result kept.
        mul.Rs    = 16'h0005;
        mul.Rt    = 16'h8001;
        mul.start = 1'b1;
        @(negedge clk);
        mul.start = 1'b0;
        repeat (5) @(negedge clk);
        mul.flush = 1'b1;
        @(negedge clk);
        mul.flush = 1'b0;
        checkOutput("flush_busy", {31'h0, mul.busy}, 32'd0);
        checkOutput("flush_done", {31'h0, mul.done}, 32'd0);
        checkOutput("flush_res", {16'h0, mul.res}, 32'h000F);
        repeat (20) @(negedge clk);

        // Flush and start together: start discarded.
        mul.Rs    = 16'h0003;
        mul.Rt    = 16'h0005;
        mul.start = 1'b1;
        mul.flush = 1'b1;
        @(negedge clk);
        mul.start = 1'b0;
        mul.flush = 1'b0;
        checkOutput("flush_start_busy", {31'h0, mul.busy}, 32'd0);
        checkOutput("flush_start_done", {31'h0, mul.done}, 32'd0);
        repeat (2) @(negedge clk);

        // Directed product table, including overflow boundaries.
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vec_rs[i], vec_rt[i], vec_res[i], vec_ovf[i]);
            waitDrain($sformatf("vec%0d", i), vec_rt[i], vec_res[i], -1);
            @(negedge clk);
        end

        // Back-to-back: start presented during the DONE cycle.
        applyStimulus("b2b_first", 16'h0003, 16'h0005, 16'h000F, 1'b0);
        waitDrain("b2b_first", 16'h0005, 16'h000F, -1);
        applyStimulus("b2b_second", 16'h0002, 16'h0009, 16'h0012, 1'b0);
        checkOutput("b2b_busy", {31'h0, mul.busy}, 32'd1);
        waitDrain("b2b_second", 16'h0009, 16'h0012, -1);
        @(negedge clk);

        // Asynchronous reset between clock edges in the middle of RUN.
        mul.Rs    = 16'hFFFF;
        mul.Rt    = 16'h8001;
        mul.start = 1'b1;
        @(negedge clk);
        mul.start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {31'h0, mul.busy}, 32'd0);
        checkOutput("midrst_done", {31'h0, mul.done}, 32'd0);
        checkOutput("midrst_res", {16'h0, mul.res}, 32'h0);
        checkOutput("midrst_ovf", {31'h0, mul.ovf}, 32'd0);
        exp_last_res = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Start accepted on the very first edge after reset release.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("post_reset", 16'h0100, 16'h0003, 16'h0300, 1'b0);
        waitDrain("post_reset", 16'h0003, 16'h0300, -1);
        @(negedge clk);
        checkOutput("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start  input  1  request a multiply of Rs by Rt; sampled on rising edge.
REQ-004 SHALL have port flush  input  1  synchronous abort of an in-flight multiply.
REQ-005 SHALL have port Rs  input  16  multiplicand, sampled only when start is accepted.
REQ-006 SHALL have port Rt  input  16  multiplier, sampled only when start is accepted.
REQ-007 SHALL have port busy  output  1  high while in RUN; pipeline stall request to decode.
REQ-008 SHALL have port done  output  1  one-cycle pulse; res/ovf valid.
REQ-009 SHALL have port res  output  16  low 16 bits of unsigned product Rs*Rt.
REQ-010 SHALL have port ovf  output  1  high when any product bit [31:16] is nonzero.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE, encoded in registers updated on rising clk.
REQ-012 SHALL accept start only in IDLE or DONE (back-to-back allowed); start in RUN SHALL be ignored with no state change.
REQ-013 On accepted start SHALL load mcand[31:0]={16'h0,Rs}, mplier[15:0]=Rt, acc[31:0]=0, count[3:0]=0, then enter RUN.
REQ-014 Each RUN cycle: if mplier[0], acc=acc+mcand (32-bit, wraps); mcand shifts left 1; mplier shifts right 1 (zero fill); count increments.
REQ-015 RUN SHALL exit to DONE on the cycle count==15 is processed (16 RUN cycles total, macro absent).
REQ-016 In DONE done SHALL be 1 for exactly one cycle; next state IDLE, or RUN if start accepted that cycle.
REQ-017 res SHALL equal acc[15:0] and ovf SHALL equal |acc[31:16]; both SHALL hold value from the last completed multiply until the next done pulse.
REQ-018 res/ovf SHALL NOT change during RUN; result registers update only on RUN->DONE transition.
REQ-019 Latency SHALL be: start sampled at edge N -> done high in cycle following edge N+16 (macro absent).
REQ-020 flush in RUN SHALL return to IDLE next edge, done SHALL NOT pulse, res/ovf SHALL keep previous values.
REQ-021 flush and start asserted together SHALL give flush priority: state IDLE, start discarded.
REQ-022 flush in IDLE or DONE SHALL force IDLE; a DONE pulse already presented that cycle remains valid.
REQ-023 busy SHALL be combinationally (state==RUN).

Reset
REQ-024 rst high SHALL immediately force state IDLE, busy=0, done=0, res=16'h0000, ovf=0, acc/mcand/mplier/count=0, regardless of clk.
REQ-025 rst asserted mid-RUN SHALL discard the operation; no done pulse after release.
REQ-026 First accepted start SHALL be on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro MULT_EARLY_EXIT_EN, when defined, SHALL end RUN on the cycle the shifted mplier becomes zero (or count==15, whichever first).
REQ-028 With MULT_EARLY_EXIT_EN defined, accepted start with Rt==0 SHALL go directly to DONE with res=0, ovf=0 (done one cycle after start edge).
REQ-029 With MULT_EARLY_EXIT_EN defined, RUN length SHALL equal index of highest set bit of Rt plus 1; results SHALL be identical to the macro-absent build.
REQ-030 Without MULT_EARLY_EXIT_EN, RUN length SHALL always be 16 cycles, independent of Rt.

Verification
REQ-031 Rs=3, Rt=5, start one cycle -> busy 16 cycles, done pulse at start+17, res=0x000F, ovf=0.
REQ-032 Rs=0x0100, Rt=0x0100 -> res=0x0000, ovf=1; Rs=0xFFFF, Rt=0xFFFF -> res=0x0001, ovf=1.
REQ-033 Start 3*5, assert flush at RUN cycle 6 -> IDLE next edge, no done, res unchanged from prior op; start during RUN with other operands -> ignored, result still 0x000F.
REQ-034 rst pulse mid-RUN (between clk edges) -> busy=0, res=0 immediately; no done for 20 cycles after.
REQ-035 MULT_EARLY_EXIT_EN: Rs=7, Rt=1 -> 1 RUN cycle, done at start+2, res=7; Rt=0 -> done at start+1, res=0.
REQ-036 Back-to-back: start held high in DONE with Rs=2, Rt=9 -> RUN re-entered without IDLE, second done res=0x0012.
